// File: rtl/turfio_cmd_decode.sv
// TURFIO command word decoder: parity check, run-control pulses, trigger
// timestamp FWFT FIFO and firmware-message byte packer, all in the aclk domain.
module turfio_cmd_decode #(
  parameter int TRIG_FIFO_DEPTH = 16,
  parameter int ERR_CNT_WIDTH   = 16
) (
  input  logic                     aclk_i,
  input  logic                     aclk_rst_n_i,
  input  logic                     en_i,
  input  logic [31:0]              command_i,
  input  logic                     command_valid_i,
  output logic                     runcmd_sync_o,
  output logic                     runcmd_reset_o,
  output logic                     runcmd_stop_o,
  output logic [13:0]              m_trig_tdata,
  output logic                     m_trig_tvalid,
  input  logic                     m_trig_tready,
  output logic [31:0]              m_msg_tdata,
  output logic                     m_msg_tvalid,
  input  logic                     m_msg_tready,
  output logic                     trig_overflow_o,
  output logic                     msg_overflow_o,
  output logic [ERR_CNT_WIDTH-1:0] parity_err_count_o,
  input  logic                     err_clear_i
);

  localparam int AW = $clog2(TRIG_FIFO_DEPTH);

  logic w_word;
  logic w_par_ok;
  logic w_accept;
  logic w_perr;

  assign w_word   = command_valid_i & en_i;
  assign w_par_ok = ~(^command_i);
  assign w_accept = w_word & w_par_ok;
  assign w_perr   = w_word & ~w_par_ok;

  logic r_sync;
  logic r_rst;
  logic r_stop;

  always_ff @(posedge aclk_i) begin
    if (!aclk_rst_n_i) begin
      r_sync <= 1'b0;
      r_rst  <= 1'b0;
      r_stop <= 1'b0;
    end else begin
      r_sync <= w_accept & (command_i[1:0] == 2'd1);
      r_rst  <= w_accept & (command_i[1:0] == 2'd2);
      r_stop <= w_accept & (command_i[1:0] == 2'd3);
    end
  end

  assign runcmd_sync_o  = r_sync;
  assign runcmd_reset_o = r_rst;
  assign runcmd_stop_o  = r_stop;

  // Trigger FIFO: pointers carry one extra bit so full and empty differ.
  logic [13:0] r_mem [TRIG_FIFO_DEPTH];
  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  logic        w_empty;
  logic        w_full;
  logic        w_pop;
  logic        w_push_req;
  logic        w_push;
  logic        w_trig_ovf;

  assign w_empty    = (r_wptr == r_rptr);
  assign w_full     = (r_wptr[AW] != r_rptr[AW]) &&
                      (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop      = ~w_empty & m_trig_tready;
  assign w_push_req = w_accept & command_i[16];
  assign w_push     = w_push_req & (~w_full | w_pop);
  assign w_trig_ovf = w_push_req & w_full & ~w_pop;

  always_ff @(posedge aclk_i) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= command_i[15:2];
  end

  always_ff @(posedge aclk_i) begin
    if (!aclk_rst_n_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  assign m_trig_tvalid = ~w_empty;
  assign m_trig_tdata  = w_empty ? 14'd0 : r_mem[r_rptr[AW-1:0]];

  // Message packer: lanes 0..2 accumulate, lane 3 completes the word.
  logic [1:0]  r_cnt;
  logic [23:0] r_acc;
  logic [31:0] r_mdata;
  logic        r_mvalid;
  logic        w_msg_wr;
  logic [1:0]  w_lane;
  logic        w_complete;
  logic        w_mpop;
  logic        w_load;
  logic        w_msg_ovf;

  assign w_msg_wr   = w_accept & command_i[25];
  assign w_lane     = command_i[26] ? 2'd0 : r_cnt;
  assign w_complete = w_msg_wr & (w_lane == 2'd3);
  assign w_mpop     = r_mvalid & m_msg_tready;
  assign w_load     = w_complete & (~r_mvalid | w_mpop);
  assign w_msg_ovf  = w_complete & r_mvalid & ~w_mpop;

  always_ff @(posedge aclk_i) begin
    if (!aclk_rst_n_i) begin
      r_cnt    <= 2'd0;
      r_acc    <= 24'd0;
      r_mdata  <= 32'd0;
      r_mvalid <= 1'b0;
    end else begin
      if (w_msg_wr) begin
        r_cnt <= w_lane + 2'd1;
        case (w_lane)
          2'd0:    r_acc[7:0]   <= command_i[24:17];
          2'd1:    r_acc[15:8]  <= command_i[24:17];
          2'd2:    r_acc[23:16] <= command_i[24:17];
          default: r_acc        <= r_acc;
        endcase
      end
      if (w_load) begin
        r_mdata  <= {command_i[24:17], r_acc};
        r_mvalid <= 1'b1;
      end else if (w_mpop) begin
        r_mvalid <= 1'b0;
      end
    end
  end

  assign m_msg_tdata  = r_mdata;
  assign m_msg_tvalid = r_mvalid;

  logic                     r_trig_ovf;
  logic                     r_msg_ovf;
  logic [ERR_CNT_WIDTH-1:0] r_err_cnt;

  // Clear beats any set event; a parity error in the clear cycle still counts once.
  always_ff @(posedge aclk_i) begin
    if (!aclk_rst_n_i) begin
      r_trig_ovf <= 1'b0;
      r_msg_ovf  <= 1'b0;
      r_err_cnt  <= '0;
    end else if (err_clear_i) begin
      r_trig_ovf <= 1'b0;
      r_msg_ovf  <= 1'b0;
      r_err_cnt  <= w_perr ? ERR_CNT_WIDTH'(1) : '0;
    end else begin
      if (w_trig_ovf) r_trig_ovf <= 1'b1;
      if (w_msg_ovf)  r_msg_ovf  <= 1'b1;
      if (w_perr && !(&r_err_cnt)) r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign trig_overflow_o    = r_trig_ovf;
  assign msg_overflow_o     = r_msg_ovf;
  assign parity_err_count_o = r_err_cnt;

endmodule

// File: tb/tb_turfio_cmd_decode.sv
// Self-checking bench for turfio_cmd_decode: directed scenarios plus random
// traffic, compared every cycle against a queue-based reference model.
module tb_turfio_cmd_decode;
  localparam int DEPTH = 16;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rstN;
  logic          en;
  logic [31:0]   cmd;
  logic          cmdValid;
  logic          sync, rrst, stop;
  logic [13:0]   trigData;
  logic          trigValid, trigReady;
  logic [31:0]   msgData;
  logic          msgValid, msgReady;
  logic          trigOvf, msgOvf;
  logic [CW-1:0] errCnt;
  logic          errClear;

  int total = 0;
  int bad   = 0;

  int          trigQ[$];
  logic [7:0]  byteQ[$];
  logic [31:0] mOutWord;
  bit          mOutValid, mTrigOvf, mMsgOvf, mSync, mRst, mStop;
  int          mCnt;

  turfio_cmd_decode #(.TRIG_FIFO_DEPTH(DEPTH), .ERR_CNT_WIDTH(CW)) dut (
    .aclk_i(clk), .aclk_rst_n_i(rstN), .en_i(en), .command_i(cmd),
    .command_valid_i(cmdValid), .runcmd_sync_o(sync), .runcmd_reset_o(rrst),
    .runcmd_stop_o(stop), .m_trig_tdata(trigData), .m_trig_tvalid(trigValid),
    .m_trig_tready(trigReady), .m_msg_tdata(msgData), .m_msg_tvalid(msgValid),
    .m_msg_tready(msgReady), .trig_overflow_o(trigOvf), .msg_overflow_o(msgOvf),
    .parity_err_count_o(errCnt), .err_clear_i(errClear)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] mkCmd(input logic [1:0] rc, input logic tv, input logic [13:0] ts,
                                        input logic mv, input logic sop, input logic [7:0] b,
                                        input logic badPar);
    logic [31:0] w;
    w = {1'b0, 4'($urandom), sop, mv, b, tv, ts, rc};
    w[31] = (^w[30:0]) ^ badPar;
    return w;
  endfunction

  task automatic modelClear();
    trigQ.delete(); byteQ.delete();
    mOutWord = '0; mOutValid = 0; mTrigOvf = 0; mMsgOvf = 0;
    mSync = 0; mRst = 0; mStop = 0; mCnt = 0;
  endtask

  // One clock: compare outputs against the model mid-cycle, then advance the model.
  task automatic applyStimulus(input logic v, input logic [31:0] c, input logic e,
                               input logic trdy, input logic mrdy, input logic clr);
    bit accept, perr, tOvfEv, mOvfEv;
    logic [31:0] word;
    cmdValid = v; cmd = c; en = e; trigReady = trdy; msgReady = mrdy; errClear = clr;
    @(negedge clk);
    checkOutput("sync", sync, mSync);
    checkOutput("reset", rrst, mRst);
    checkOutput("stop", stop, mStop);
    checkOutput("trigValid", trigValid, trigQ.size() > 0);
    if (trigQ.size() > 0) checkOutput("trigData", trigData, trigQ[0]);
    checkOutput("msgValid", msgValid, mOutValid);
    if (mOutValid) checkOutput("msgData", msgData, mOutWord);
    checkOutput("trigOvf", trigOvf, mTrigOvf);
    checkOutput("msgOvf", msgOvf, mMsgOvf);
    checkOutput("errCnt", errCnt, mCnt);
    accept = v && e && ((^c) == 1'b0);
    perr   = v && e && ((^c) == 1'b1);
    tOvfEv = 0; mOvfEv = 0;
    mSync = accept && c[1:0] == 2'd1;
    mRst  = accept && c[1:0] == 2'd2;
    mStop = accept && c[1:0] == 2'd3;
    if (trigQ.size() > 0 && trdy) void'(trigQ.pop_front());
    if (accept && c[16]) begin
      if (trigQ.size() < DEPTH) trigQ.push_back(int'(c[15:2]));
      else tOvfEv = 1;
    end
    if (mOutValid && mrdy) mOutValid = 0;
    if (accept && c[25]) begin
      if (c[26]) byteQ.delete();
      byteQ.push_back(c[24:17]);
      if (byteQ.size() == 4) begin
        word = {byteQ[3], byteQ[2], byteQ[1], byteQ[0]};
        byteQ.delete();
        if (!mOutValid) begin mOutWord = word; mOutValid = 1; end
        else mOvfEv = 1;
      end
    end
    if (clr) begin
      mTrigOvf = 0; mMsgOvf = 0; mCnt = perr ? 1 : 0;
    end else begin
      if (tOvfEv) mTrigOvf = 1;
      if (mOvfEv) mMsgOvf = 1;
      if (perr && mCnt < CMAX) mCnt++;
    end
    @(posedge clk); #1;
  endtask

  task automatic doReset();
    rstN = 0; cmdValid = 0; cmd = '0; errClear = 0;
    @(posedge clk); #1;
    modelClear();
    rstN = 1;
  endtask

  task automatic idle(input logic trdy, input logic mrdy);
    applyStimulus(0, 32'd0, 1, trdy, mrdy, 0);
  endtask

  task automatic sendByte(input logic [7:0] b, input logic sop, input logic mrdy);
    applyStimulus(1, mkCmd(2'd0, 0, 14'd0, 1, sop, b, 0), 1, 0, mrdy, 0);
  endtask

  initial begin
    logic [7:0] seq[6];
    int bias;
    rstN = 0; en = 0; cmd = '0; cmdValid = 0; trigReady = 0; msgReady = 0; errClear = 0;
    modelClear();
    doReset();
    checkOutput("rstTrigValid", trigValid, 0);
    checkOutput("rstMsgValid", msgValid, 0);
    checkOutput("rstCnt", errCnt, 0);

    applyStimulus(1, 32'h0000_0001, 1, 0, 1, 0);
    checkOutput("badParNoSync", sync, 0);
    checkOutput("badParCnt", errCnt, 1);
    applyStimulus(1, 32'h8000_0001, 1, 0, 1, 0);
    checkOutput("goodSync", sync, 1);
    idle(0, 1);
    checkOutput("syncOneCycle", sync, 0);
    checkOutput("cntStays", errCnt, 1);

    for (int i = 1; i <= 17; i++) applyStimulus(1, mkCmd(0, 1, 14'(i), 0, 0, 0, 0), 1, 0, 1, 0);
    checkOutput("trigOvfSet", trigOvf, 1);
    for (int i = 1; i <= 16; i++) begin
      checkOutput("trigOrder", trigData, i);
      idle(1, 1);
    end
    checkOutput("trigDrained", trigValid, 0);
    applyStimulus(0, 32'd0, 1, 0, 1, 1);

    for (int i = 1; i <= 16; i++) applyStimulus(1, mkCmd(0, 1, 14'(i), 0, 0, 0, 0), 1, 0, 1, 0);
    applyStimulus(1, mkCmd(0, 1, 14'h3FFF, 0, 0, 0, 0), 1, 1, 1, 0);
    checkOutput("fullPopPushNoOvf", trigOvf, 0);
    for (int i = 0; i < 15; i++) idle(1, 1);
    checkOutput("lastTrig", trigData, 14'h3FFF);
    idle(1, 1);
    checkOutput("fifoEmpty", trigValid, 0);

    sendByte(8'h11, 1, 1); sendByte(8'h22, 0, 1); sendByte(8'h33, 0, 1); sendByte(8'h44, 0, 1);
    checkOutput("pack1Valid", msgValid, 1);
    checkOutput("pack1Data", msgData, 32'h4433_2211);
    idle(0, 1);
    seq = '{8'hAA, 8'hBB, 8'h55, 8'h66, 8'h77, 8'h88};
    for (int i = 0; i < 6; i++) sendByte(seq[i], i == 2, 1);
    checkOutput("sopRestartData", msgData, 32'h8877_6655);
    idle(0, 1);
    checkOutput("onlyOneWord", msgValid, 0);

    for (int i = 1; i <= 8; i++) sendByte(8'(i), 0, 0);
    checkOutput("heldFirst", msgData, 32'h0403_0201);
    checkOutput("msgOvfSet", msgOvf, 1);
    applyStimulus(0, 32'd0, 1, 0, 0, 1);
    checkOutput("clrMsgOvf", msgOvf, 0);
    checkOutput("clrCnt", errCnt, 0);
    idle(0, 1);

    for (int i = 0; i < 3; i++) applyStimulus(1, mkCmd(0, 1, 14'(100 + i), 0, 0, 0, 0), 1, 0, 1, 0);
    sendByte(8'hE1, 1, 0); sendByte(8'hE2, 0, 0);
    doReset();
    checkOutput("midRstTrig", trigValid, 0);
    for (int i = 1; i <= 4; i++) sendByte(8'(8'hC0 + i), 0, 0);
    checkOutput("postRstPack", msgData, 32'hC4C3_C2C1);
    idle(1, 1);

    for (int i = 0; i < (1 << CW) + 5; i++) applyStimulus(1, mkCmd(0, 0, 0, 0, 0, 0, 1), 1, 1, 1, 0);
    checkOutput("cntSaturate", errCnt, CMAX);
    applyStimulus(1, mkCmd(0, 0, 0, 0, 0, 0, 1), 1, 1, 1, 1);
    checkOutput("clrWithErr", errCnt, 1);

    bias = 2;
    for (int n = 0; n < 3000; n++) begin
      if (n % 256 == 0) bias = int'($urandom_range(0, 4));
      if ($urandom_range(0, 499) == 0) doReset();
      applyStimulus($urandom_range(0, 3) != 0,
                    mkCmd(2'($urandom), $urandom_range(0, 1) == 0, 14'($urandom),
                          $urandom_range(0, 1) == 0, $urandom_range(0, 7) == 0,
                          8'($urandom), $urandom_range(0, 9) == 0),
                    $urandom_range(0, 15) != 0, $urandom_range(0, 4) < bias,
                    $urandom_range(0, 4) < bias, $urandom_range(0, 63) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
